argon_regfile_mp: RTL and testbench
===================================

// Module: argon_regfile_mp
// PURPOSE
//   Multi-port register file for the Argon core.
//   - READPORTS asynchronous read ports and two write ports (A and B).
//   - Per-register busy scoreboard: issue reserves a destination, writeback clears it.
//   - Register 0 is hardwired zero: it is never written, never reserved and never busy.
//   - Sits between decode/issue (reads, reservations) and the writeback stages (writes).
// PARAMETERS
//   REGISTERS   16  number of architectural registers, including the zero register
//   INDEXWIDTH  4   register index width; REGISTERS must be <= 2**INDEXWIDTH
//   DATAWIDTH   16  width of each register
//   READPORTS   3   number of read ports, >= 1
// PORTS
//   i_clk         in   1                     clock; all state updates on posedge
//   i_reset_n     in   1                     reset; asynchronous, active-low
//   i_writeEnA    in   1                     write port A enable
//   i_selectWA    in   INDEXWIDTH            write port A index
//   i_wdataA      in   DATAWIDTH             write port A data
//   i_writeEnB    in   1                     write port B enable
//   i_selectWB    in   INDEXWIDTH            write port B index
//   i_wdataB      in   DATAWIDTH             write port B data
//   i_selectR     in   READPORTS*INDEXWIDTH  read indices; port k at [k*INDEXWIDTH +: INDEXWIDTH]
//   o_rdata       out  READPORTS*DATAWIDTH   read data; port k at [k*DATAWIDTH +: DATAWIDTH]
//   o_busy        out  READPORTS             busy flag of the register selected on read port k
//   i_reserveEn   in   1                     request to mark a destination register busy
//   i_selectRsv   in   INDEXWIDTH            index to reserve
//   o_reserveOk   out  1                     reservation accepted this cycle
// BEHAVIOUR
//   Reset (i_reset_n low, asynchronous)
//   - All registers clear to 0; all busy bits clear to 0.
//   - Consequently o_rdata = 0, o_busy = 0, o_reserveOk = 0.
//   - Reset asserted mid-write: the write is lost. No write or reserve takes effect while reset is low.
//   Reads (combinational, 0 cycles)
//   - o_rdata[k] = regfile[i_selectR[k]].
//   - Index 0, or any index >= REGISTERS, reads 0 with busy 0.
//   Writes (posedge)
//   - Each enabled port with index in 1..REGISTERS-1 writes its data.
//   - Index 0 or out of range: the write is dropped.
//   - Both ports to the same index: port B wins; the register takes i_wdataB.
//   Scoreboard
//   - busy[r] is cleared at the edge when either enabled write port targets r.
//   - o_reserveOk = i_reserveEn && (i_selectRsv == 0 || !busy[i_selectRsv]) && index < REGISTERS.
//   - On o_reserveOk with a nonzero index, busy[i_selectRsv] is set at the edge.
//   - Reserve on a busy register: rejected, o_reserveOk = 0, no state change. Issue must stall.
//   - Reserve and write to the same register in one cycle: the set wins; busy stays 1 as a new pending write.
//   - Reserve of index 0: o_reserveOk = 1, no state change.
//   - Writes are not gated by busy; writing a non-busy register is legal.
// CONFIGURATION
//   ARGON_RF_BYPASS_EN defined
//   - Write-through forwarding. A read whose index matches an enabled same-cycle write
//     returns that write data (B over A when both match).
//   - Its o_busy reads 0, and a same-cycle reservation of that register is accepted.
//   ARGON_RF_BYPASS_EN undefined
//   - Reads return the stored value; new data is visible from the cycle after the edge.
//   - o_busy and o_reserveOk use the registered busy bits only.
// TESTING
//   1. Reset, then read all indices on every port -> o_rdata = 0, o_busy = 0.
//   2. Write A r3=0x1234, then read r3 and r0 -> 0x1234 and 0; write r0=0xFFFF -> r0 still reads 0.
//   3. Same cycle, A r5=0x1111 and B r5=0x2222 -> r5 reads 0x2222.
//   4. Reserve r7 -> ok=1 and o_busy=1 next cycle; reserve r7 again -> ok=0; write r7=0x00AA -> busy 0, data 0x00AA.
//   5. Reserve r2 while port A writes r2 -> busy[2] = 1 after the edge.
//      With ARGON_RF_BYPASS_EN: read r2 during a write of 0x5A5A -> 0x5A5A in the same cycle.
//   6. Drop i_reset_n mid-sequence with r4=0xBEEF busy -> immediately r4 = 0, busy 0, ok 0.

Source files
------------

// File: rtl/argon_regfile_mp_if.sv
// argon_regfile_mp_if: read, write and reservation bus of the Argon register file
interface argon_regfile_mp_if #(
  parameter int INDEXWIDTH = 4,
  parameter int DATAWIDTH  = 16,
  parameter int READPORTS  = 3
);
  logic                          i_writeEnA;
  logic [INDEXWIDTH-1:0]         i_selectWA;
  logic [DATAWIDTH-1:0]          i_wdataA;
  logic                          i_writeEnB;
  logic [INDEXWIDTH-1:0]         i_selectWB;
  logic [DATAWIDTH-1:0]          i_wdataB;
  logic [READPORTS*INDEXWIDTH-1:0] i_selectR;
  logic [READPORTS*DATAWIDTH-1:0]  o_rdata;
  logic [READPORTS-1:0]          o_busy;
  logic                          i_reserveEn;
  logic [INDEXWIDTH-1:0]         i_selectRsv;
  logic                          o_reserveOk;
  modport master (
    output i_writeEnA, i_selectWA, i_wdataA, i_writeEnB, i_selectWB, i_wdataB,
           i_selectR, i_reserveEn, i_selectRsv,
    input  o_rdata, o_busy, o_reserveOk
  );
  modport slave (
    input  i_writeEnA, i_selectWA, i_wdataA, i_writeEnB, i_selectWB, i_wdataB,
           i_selectR, i_reserveEn, i_selectRsv,
    output o_rdata, o_busy, o_reserveOk
  );
endinterface

// File: rtl/argon_regfile_mp.sv
// argon_regfile_mp: multi-port register file with busy scoreboard; ARGON_RF_BYPASS_EN enables write-through forwarding
module argon_regfile_mp #(
  parameter int REGISTERS  = 16,
  parameter int INDEXWIDTH = 4,
  parameter int DATAWIDTH  = 16,
  parameter int READPORTS  = 3
) (
  input logic               i_clk,
  input logic               i_reset_n,
  argon_regfile_mp_if.slave bus
);
  localparam logic [INDEXWIDTH:0] NREG = REGISTERS[INDEXWIDTH:0];
  logic [DATAWIDTH-1:0] regs [REGISTERS];
  logic [REGISTERS-1:0] busy, busy_next;
  logic wa_ok, wb_ok, rsv_range, rsv_busy, rsv_clr, rsv_set;
  logic [INDEXWIDTH-1:0] rsv_idx;
  // writes only land on real, nonzero registers and never while reset is held
  assign wa_ok = i_reset_n && bus.i_writeEnA && bus.i_selectWA != '0 && {1'b0, bus.i_selectWA} < NREG;
  assign wb_ok = i_reset_n && bus.i_writeEnB && bus.i_selectWB != '0 && {1'b0, bus.i_selectWB} < NREG;
  assign rsv_idx = bus.i_selectRsv;
  assign rsv_range = {1'b0, rsv_idx} < NREG;
  assign rsv_busy = rsv_range && busy[rsv_idx];
`ifdef ARGON_RF_BYPASS_EN
  assign rsv_clr = (wa_ok && bus.i_selectWA == rsv_idx) || (wb_ok && bus.i_selectWB == rsv_idx);
`else
  assign rsv_clr = 1'b0;
`endif
  assign bus.o_reserveOk = i_reset_n && bus.i_reserveEn && rsv_range && !(rsv_busy && !rsv_clr);
  assign rsv_set = bus.o_reserveOk && rsv_idx != '0;
  for (genvar k = 0; k < READPORTS; k++) begin : g_rd
    logic [INDEXWIDTH-1:0] idx;
    logic live;
    assign idx = bus.i_selectR[k*INDEXWIDTH +: INDEXWIDTH];
    assign live = idx != '0 && {1'b0, idx} < NREG;
`ifdef ARGON_RF_BYPASS_EN
    logic hit_a, hit_b;
    assign hit_a = wa_ok && bus.i_selectWA == idx;
    assign hit_b = wb_ok && bus.i_selectWB == idx;
    assign bus.o_rdata[k*DATAWIDTH +: DATAWIDTH] = hit_b ? bus.i_wdataB : hit_a ? bus.i_wdataA : live ? regs[idx] : '0;
    assign bus.o_busy[k] = live && busy[idx] && !(hit_a || hit_b);
`else
    assign bus.o_rdata[k*DATAWIDTH +: DATAWIDTH] = live ? regs[idx] : '0;
    assign bus.o_busy[k] = live && busy[idx];
`endif
  end
  // a reservation set overrides a same-cycle writeback clear; r0 never busy
  always_comb begin
    busy_next = '0;
    for (int r = 1; r < REGISTERS; r++)
      busy_next[r] = (rsv_set && rsv_idx == r[INDEXWIDTH-1:0]) ? 1'b1 :
                     ((wa_ok && bus.i_selectWA == r[INDEXWIDTH-1:0]) ||
                      (wb_ok && bus.i_selectWB == r[INDEXWIDTH-1:0])) ? 1'b0 : busy[r];
  end
  // register storage and scoreboard; port B is applied last so it wins on a shared index
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      regs <= '{default: '0};
      busy <= '0;
    end else begin
      if (wa_ok) regs[bus.i_selectWA] <= bus.i_wdataA;
      if (wb_ok) regs[bus.i_selectWB] <= bus.i_wdataB;
      busy <= busy_next;
    end
  end
endmodule

// File: tb/tb_argon_regfile_mp.sv
// tb_argon_regfile_mp: directed scoreboard bench for argon_regfile_mp
module tb_argon_regfile_mp;
  logic i_clk = 1'b0;
  logic i_reset_n = 1'b0;
  always #5 i_clk = ~i_clk;
  argon_regfile_mp_if #(.INDEXWIDTH(4), .DATAWIDTH(16), .READPORTS(3)) bus ();
  argon_regfile_mp #(.REGISTERS(16), .INDEXWIDTH(4), .DATAWIDTH(16), .READPORTS(3)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .bus(bus)
  );
`ifdef ARGON_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef struct {string tag; int kind; logic [15:0] val;} exp_t;
  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  function automatic logic [15:0] obs(int kind);
    case (kind)
      0: return bus.o_rdata[15:0];
      1: return bus.o_rdata[31:16];
      2: return bus.o_rdata[47:32];
      3: return {15'b0, bus.o_busy[0]};
      4: return {15'b0, bus.o_busy[1]};
      5: return {15'b0, bus.o_busy[2]};
      default: return {15'b0, bus.o_reserveOk};
    endcase
  endfunction
  task automatic expect_v(string tag, int kind, logic [15:0] v);
    sb.push_back('{tag, kind, v});
  endtask
  task automatic expect_rd(string tag, int port, logic [15:0] d, logic b);
    expect_v(tag, port, d);
    expect_v(tag, port + 3, {15'b0, b});
  endtask
  task automatic check_all();
    #1;
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      logic [15:0] got = obs(e.kind);
      checks++;
      assert (got === e.val) else begin
        failures++;
        $error("FAIL %s kind=%0d observed=%h expected=%h", e.tag, e.kind, got, e.val);
      end
    end
  endtask
  task automatic sel(int a, int b, int c);
    bus.i_selectR = {c[3:0], b[3:0], a[3:0]};
  endtask
  task automatic idle();
    bus.i_writeEnA = 0; bus.i_selectWA = 0; bus.i_wdataA = 0;
    bus.i_writeEnB = 0; bus.i_selectWB = 0; bus.i_wdataB = 0;
    bus.i_reserveEn = 0; bus.i_selectRsv = 0;
  endtask
  task automatic wr_a(int idx, logic [15:0] d);
    bus.i_writeEnA = 1; bus.i_selectWA = idx[3:0]; bus.i_wdataA = d;
  endtask
  task automatic wr_b(int idx, logic [15:0] d);
    bus.i_writeEnB = 1; bus.i_selectWB = idx[3:0]; bus.i_wdataB = d;
  endtask
  task automatic rsv(int idx);
    bus.i_reserveEn = 1; bus.i_selectRsv = idx[3:0];
  endtask
  task automatic step();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    idle();
    sel(0, 0, 0);
    @(negedge i_clk);
    for (int i = 0; i < 16; i++) begin
      sel(i, i, i);
      for (int p = 0; p < 3; p++) expect_rd("rst_rd", p, 16'h0, 1'b0);
      check_all();
    end
    rsv(5);
    expect_v("rst_rsv_ok", 6, 16'h0);
    check_all();
    idle();
    step();
    i_reset_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      sel(i, (i + 5) % 16, (i + 11) % 16);
      for (int p = 0; p < 3; p++) expect_rd("post_rst_rd", p, 16'h0, 1'b0);
      check_all();
    end
    wr_a(3, 16'h1234);
    sel(3, 0, 3);
    expect_rd("wr3_same_cycle", 0, BYP ? 16'h1234 : 16'h0, 1'b0);
    check_all();
    step();
    idle();
    expect_rd("r3", 0, 16'h1234, 1'b0);
    expect_rd("r0", 1, 16'h0, 1'b0);
    expect_rd("r3_p2", 2, 16'h1234, 1'b0);
    check_all();
    wr_a(0, 16'hFFFF);
    wr_b(0, 16'hFFFF);
    step();
    idle();
    sel(0, 3, 0);
    expect_rd("r0_after_wr", 0, 16'h0, 1'b0);
    expect_rd("r3_kept", 1, 16'h1234, 1'b0);
    check_all();
    wr_a(5, 16'h1111);
    wr_b(5, 16'h2222);
    step();
    idle();
    wr_a(8, 16'h0808);
    wr_b(9, 16'h0909);
    step();
    idle();
    sel(8, 9, 5);
    expect_rd("r8_a", 0, 16'h0808, 1'b0);
    expect_rd("r9_b", 1, 16'h0909, 1'b0);
    expect_rd("r5_b_wins", 2, 16'h2222, 1'b0);
    check_all();
    rsv(7);
    sel(7, 0, 0);
    expect_v("rsv7_ok", 6, 16'h1);
    expect_rd("r7_pre_rsv", 0, 16'h0, 1'b0);
    check_all();
    step();
    expect_v("rsv7_again_ok", 6, 16'h0);
    expect_rd("r7_busy", 0, 16'h0, 1'b1);
    check_all();
    step();
    expect_rd("r7_still_busy", 0, 16'h0, 1'b1);
    check_all();
    idle();
    wr_a(7, 16'h00AA);
    expect_rd("wr7_same_cycle", 0, BYP ? 16'h00AA : 16'h0, !BYP);
    check_all();
    step();
    idle();
    expect_rd("r7_written", 0, 16'h00AA, 1'b0);
    check_all();
    rsv(0);
    sel(0, 7, 7);
    expect_v("rsv0_ok", 6, 16'h1);
    check_all();
    step();
    expect_rd("r0_never_busy", 0, 16'h0, 1'b0);
    expect_v("rsv0_ok_again", 6, 16'h1);
    check_all();
    idle();
    rsv(2);
    wr_a(2, 16'h5A5A);
    sel(2, 2, 2);
    expect_v("rsv2_with_wr_ok", 6, 16'h1);
    expect_rd("r2_fwd", 0, BYP ? 16'h5A5A : 16'h0, 1'b0);
    check_all();
    step();
    idle();
    expect_rd("r2_set_wins", 0, 16'h5A5A, 1'b1);
    check_all();
    rsv(2);
    wr_a(2, 16'h6B6B);
    expect_v("rsv2_busy_wr", 6, BYP ? 16'h1 : 16'h0);
    expect_rd("r2_busy_wr", 0, BYP ? 16'h6B6B : 16'h5A5A, BYP ? 1'b0 : 1'b1);
    check_all();
    step();
    idle();
    expect_rd("r2_after", 0, 16'h6B6B, BYP);
    check_all();
    wr_b(2, 16'h7C7C);
    step();
    idle();
    expect_rd("r2_b_clears", 1, 16'h7C7C, 1'b0);
    check_all();
    wr_a(4, 16'hBEEF);
    step();
    idle();
    rsv(4);
    step();
    idle();
    sel(4, 3, 4);
    expect_rd("r4_busy", 0, 16'hBEEF, 1'b1);
    expect_rd("r3_before_rst", 1, 16'h1234, 1'b0);
    check_all();
    wr_a(3, 16'h7777);
    rsv(9);
    i_reset_n = 1'b0;
    expect_rd("rst_r4", 0, 16'h0, 1'b0);
    expect_rd("rst_r3", 1, 16'h0, 1'b0);
    expect_v("rst_ok", 6, 16'h0);
    check_all();
    step();
    expect_rd("rst_wr_lost", 1, 16'h0, 1'b0);
    check_all();
    i_reset_n = 1'b1;
    idle();
    step();
    sel(3, 4, 9);
    rsv(9);
    expect_rd("after_rst_r3", 0, 16'h0, 1'b0);
    expect_rd("after_rst_r4", 1, 16'h0, 1'b0);
    expect_v("after_rst_rsv9", 6, 16'h1);
    check_all();
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
